// File: rtl/metro_text_scroller_if.sv
// Signal bundle between the station-selection logic (master) and the
// metro_text_scroller (slave) that feeds the 4-digit display driver.
interface metro_text_scroller_if;
  logic       start;
  logic       stop;
  logic [1:0] station_sel;
  logic [4:0] thousands;
  logic [4:0] hundreds;
  logic [4:0] tens;
  logic [4:0] ones;
  logic       busy;
  logic       done;

  modport master (
    output start, stop, station_sel,
    input  thousands, hundreds, tens, ones, busy, done
  );

  modport slave (
    input  start, stop, station_sel,
    output thousands, hundreds, tens, ones, busy, done
  );
endinterface

// File: rtl/metro_text_scroller.sv
// Scrolls a ROM-held metro station name right-to-left across four letter digits.
// Define SCROLL_LOOP_EN to wrap to the first frame forever instead of finishing once.
module metro_text_scroller #(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  metro_text_scroller_if.slave    if_scr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCROLL = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [4:0] LT_A  = 5'd0;
  localparam logic [4:0] LT_D  = 5'd3;
  localparam logic [4:0] LT_E  = 5'd4;
  localparam logic [4:0] LT_G  = 5'd5;
  localparam logic [4:0] LT_H  = 5'd6;
  localparam logic [4:0] LT_I  = 5'd8;
  localparam logic [4:0] LT_L  = 5'd9;
  localparam logic [4:0] LT_M  = 5'd10;
  localparam logic [4:0] LT_N  = 5'd11;
  localparam logic [4:0] LT_O  = 5'd12;
  localparam logic [4:0] LT_P  = 5'd13;
  localparam logic [4:0] LT_S  = 5'd15;
  localparam logic [4:0] LT_T  = 5'd16;
  localparam logic [4:0] LT_U  = 5'd17;
  localparam logic [4:0] LT_Y  = 5'd18;
  localparam logic [4:0] LT_SP = 5'd19;
  localparam logic [4:0] LT_DASH = 5'd20;

  localparam logic [CNT_W-1:0] LP_TICK_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_sel;
  logic [3:0]       r_frame;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_state_nxt;
  logic [1:0]       w_sel_nxt;
  logic [3:0]       w_frame_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tick;
  logic [3:0]       w_last_frame;
  logic             w_scroll_nxt;

  function automatic logic [3:0] msg_len(input logic [1:0] sel);
    case (sel)
      2'd0:    msg_len = 4'd4;
      2'd1:    msg_len = 4'd7;
      2'd2:    msg_len = 4'd7;
      default: msg_len = 4'd8;
    endcase
  endfunction

  // Any index past the end of a name falls into the default arm and reads as SPACE.
  function automatic logic [4:0] rom_char(input logic [1:0] sel, input logic [4:0] idx);
    rom_char = LT_SP;
    case (sel)
      2'd0: case (idx)
        5'd0: rom_char = LT_U;  5'd1: rom_char = LT_L;
        5'd2: rom_char = LT_U;  5'd3: rom_char = LT_S;
        default: rom_char = LT_SP;
      endcase
      2'd1: case (idx)
        5'd0: rom_char = LT_S;  5'd1: rom_char = LT_I;
        5'd2: rom_char = LT_H;  5'd3: rom_char = LT_H;
        5'd4: rom_char = LT_I;  5'd5: rom_char = LT_Y;
        5'd6: rom_char = LT_E;
        default: rom_char = LT_SP;
      endcase
      2'd2: case (idx)
        5'd0: rom_char = LT_M;  5'd1: rom_char = LT_A;
        5'd2: rom_char = LT_L;  5'd3: rom_char = LT_T;
        5'd4: rom_char = LT_E;  5'd5: rom_char = LT_P;
        5'd6: rom_char = LT_E;
        default: rom_char = LT_SP;
      endcase
      default: case (idx)
        5'd0: rom_char = LT_T;  5'd1: rom_char = LT_A;
        5'd2: rom_char = LT_N;  5'd3: rom_char = LT_D;
        5'd4: rom_char = LT_O;  5'd5: rom_char = LT_G;
        5'd6: rom_char = LT_A;  5'd7: rom_char = LT_N;
        default: rom_char = LT_SP;
      endcase
    endcase
  endfunction

  // Digit k (0 = thousands) of frame f shows stream index f-3+k; negative reads SPACE.
  function automatic logic [4:0] stream_char(input logic [1:0] sel, input logic [3:0] frame,
                                             input logic [1:0] k);
    logic [4:0] pos;
    pos = {1'b0, frame} + {3'b000, k};
    if (pos < 5'd3) stream_char = LT_SP;
    else            stream_char = rom_char(sel, pos - 5'd3);
  endfunction

  assign w_tick       = (r_cnt == LP_TICK_LAST);
  assign w_last_frame = msg_len(r_sel) + 4'd3;
  assign w_scroll_nxt = (w_state_nxt == ST_SCROLL);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_frame_nxt = r_frame;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_SCROLL: begin
        if (if_scr.start) begin
          w_sel_nxt   = if_scr.station_sel;
          w_frame_nxt = 4'd0;
          w_cnt_nxt   = '0;
        end else if (if_scr.stop) begin
          w_state_nxt = ST_IDLE;
          w_frame_nxt = 4'd0;
          w_cnt_nxt   = '0;
        end else if (w_tick) begin
          w_cnt_nxt = '0;
          if (r_frame == w_last_frame) begin
            w_frame_nxt = 4'd0;
`ifdef SCROLL_LOOP_EN
            w_state_nxt = ST_SCROLL;
`else
            w_state_nxt = ST_DONE;
`endif
          end else begin
            w_frame_nxt = r_frame + 4'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept start; DONE always falls back to IDLE otherwise.
        w_frame_nxt = 4'd0;
        w_cnt_nxt   = '0;
        if (if_scr.start) begin
          w_state_nxt = ST_SCROLL;
          w_sel_nxt   = if_scr.station_sel;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_sel            <= 2'd0;
      r_frame          <= 4'd0;
      r_cnt            <= '0;
      if_scr.thousands <= LT_DASH;
      if_scr.hundreds  <= LT_DASH;
      if_scr.tens      <= LT_DASH;
      if_scr.ones      <= LT_DASH;
      if_scr.busy      <= 1'b0;
      if_scr.done      <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_sel            <= w_sel_nxt;
      r_frame          <= w_frame_nxt;
      r_cnt            <= w_cnt_nxt;
      // Outputs are built from next-state values so frame 0 appears on the start edge.
      if_scr.thousands <= w_scroll_nxt ? stream_char(w_sel_nxt, w_frame_nxt, 2'd0) : LT_DASH;
      if_scr.hundreds  <= w_scroll_nxt ? stream_char(w_sel_nxt, w_frame_nxt, 2'd1) : LT_DASH;
      if_scr.tens      <= w_scroll_nxt ? stream_char(w_sel_nxt, w_frame_nxt, 2'd2) : LT_DASH;
      if_scr.ones      <= w_scroll_nxt ? stream_char(w_sel_nxt, w_frame_nxt, 2'd3) : LT_DASH;
      if_scr.busy      <= w_scroll_nxt;
      if_scr.done      <= (w_state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_metro_text_scroller.sv
// Directed self-checking bench for metro_text_scroller with TICK_CYCLES=4.
// Digits are compared packed as {thousands,hundreds,tens,ones}, 5 bits each.
module tb_metro_text_scroller;

  localparam int TICK = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  metro_text_scroller_if u_if ();

  metro_text_scroller #(
    .TICK_CYCLES(TICK),
    .CNT_W      (3)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .if_scr(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] dg(input int a, input int b, input int c, input int d);
    dg = {a[4:0], b[4:0], c[4:0], d[4:0]};
  endfunction

  // Hand-derived ULUS frames 0..7.
  logic [19:0] ulus [8];

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  function automatic logic [19:0] digits();
    digits = {u_if.thousands, u_if.hundreds, u_if.tens, u_if.ones};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [1:0] sel, input logic with_stop);
    u_if.start       = 1'b1;
    u_if.stop        = with_stop;
    u_if.station_sel = sel;
    step(1);
    u_if.start = 1'b0;
    u_if.stop  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dig"}, digits(), dg(20, 20, 20, 20));
    check({tag, "_busy"}, {19'd0, u_if.busy}, 20'd0);
    check({tag, "_done"}, {19'd0, u_if.done}, 20'd0);
  endtask

  initial begin
    int seen_done;
    total = 0;
    bad   = 0;
    ulus[0] = dg(19, 19, 19, 17);
    ulus[1] = dg(19, 19, 17, 9);
    ulus[2] = dg(19, 17, 9, 17);
    ulus[3] = dg(17, 9, 17, 15);
    ulus[4] = dg(9, 17, 15, 19);
    ulus[5] = dg(17, 15, 19, 19);
    ulus[6] = dg(15, 19, 19, 19);
    ulus[7] = dg(19, 19, 19, 19);

    u_if.start       = 1'b0;
    u_if.stop        = 1'b0;
    u_if.station_sel = 2'd0;
    rst_n            = 1'b0;
    step(3);
    check_idle("reset");
    rst_n = 1'b1;
    step(3);
    check_idle("post_reset");

`ifdef SCROLL_LOOP_EN
    pulse_start(2'd0, 1'b0);
    for (int i = 0; i < 3 * 8 * TICK; i++) begin
      check("loop_frame", digits(), ulus[(i / TICK) % 8]);
      check("loop_done", {19'd0, u_if.done}, 20'd0);
      step(1);
    end
    check("loop_wrap", digits(), ulus[0]);
    u_if.stop = 1'b1;
    step(1);
    u_if.stop = 1'b0;
    check_idle("loop_stop");
`else
    // ULUS one-shot: 8 frames of TICK cycles each, then a single DONE cycle.
    pulse_start(2'd0, 1'b0);
    for (int i = 0; i < 8 * TICK; i++) begin
      check("ulus_frame", digits(), ulus[i / TICK]);
      check("ulus_busy", {19'd0, u_if.busy}, 20'd1);
      check("ulus_done_low", {19'd0, u_if.done}, 20'd0);
      step(1);
    end
    check("ulus_done_pulse", {19'd0, u_if.done}, 20'd1);
    check("ulus_done_busy", {19'd0, u_if.busy}, 20'd0);
    check("ulus_done_dig", digits(), dg(20, 20, 20, 20));
    step(1);
    check_idle("ulus_after");

    // TANDOGAN: 12 frames.
    pulse_start(2'd3, 1'b0);
    check("tand_f0", digits(), dg(19, 19, 19, 16));
    step(7 * TICK);
    check("tand_f7", digits(), dg(12, 5, 0, 11));
    step(5 * TICK - 1);
    check("tand_f11", digits(), dg(19, 19, 19, 19));
    check("tand_busy_end", {19'd0, u_if.busy}, 20'd1);
    step(1);
    check("tand_done", {19'd0, u_if.done}, 20'd1);
    step(1);
    check_idle("tand_after");
`endif

    // Stop at frame 2 of SIHHIYE: no done pulse afterwards.
    pulse_start(2'd1, 1'b0);
    step(2 * TICK);
    check("sih_f2", digits(), dg(19, 15, 8, 6));
    u_if.stop = 1'b1;
    step(1);
    u_if.stop = 1'b0;
    check_idle("stop");
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (u_if.done) seen_done++;
      step(1);
    end
    check("stop_no_done", 20'(seen_done), 20'd0);

    // Restart into MALTEPE mid-frame with stop in the same cycle: start wins.
    pulse_start(2'd1, 1'b0);
    step(5 * TICK);
    check("sih_f5", digits(), dg(6, 6, 8, 18));
    step(1);
    pulse_start(2'd2, 1'b1);
    check("malt_f0", digits(), dg(19, 19, 19, 10));
    check("malt_busy", {19'd0, u_if.busy}, 20'd1);
    u_if.station_sel = 2'd3;
    step(TICK - 1);
    check("malt_f0_hold", digits(), dg(19, 19, 19, 10));
    step(1);
    check("malt_f1", digits(), dg(19, 19, 10, 0));
    step(TICK);
    check("malt_f2_sel_ignored", digits(), dg(19, 10, 0, 9));

    // Asynchronous reset mid-scroll clears immediately, between clock edges.
    rst_n = 1'b0;
    #2;
    check_idle("async_reset");
    step(1);
    rst_n = 1'b1;
    step(1);

    // stop while idle is ignored.
    u_if.stop = 1'b1;
    step(1);
    u_if.stop = 1'b0;
    check_idle("idle_stop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/metro_text_scroller.md
Name: metro_text_scroller

Overview:
- Upstream feeder for the 4-digit seven-segment display driver; produces the four 5-bit letter codes (thousands..ones) that the driver multiplexes onto the display.
- Holds a small ROM of metro station names and scrolls the selected name right-to-left across the four digits at a fixed tick rate.
- Sits between the station-selection logic and the display driver, on the 100 MHz system clock.

Parameters:
- TICK_CYCLES, 50_000_000, clock cycles per scroll frame (0.5 s at 100 MHz); legal range 2..2^26-1.
- CNT_W, 26, width of the tick counter; must satisfy 2^CNT_W > TICK_CYCLES.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse: begin scrolling the message selected by station_sel.
- stop  input  1  single-cycle pulse: abort the scroll and return to idle.
- station_sel  input  2  message select, sampled only on start.
- thousands  output  5  leftmost digit letter code, registered.
- hundreds  output  5  letter code, registered.
- tens  output  5  letter code, registered.
- ones  output  5  rightmost digit letter code, registered.
- busy  output  1  high while scrolling.
- done  output  1  one-cycle pulse when a scroll finishes.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Letter codes are fixed: A=0 B=1 C=2 D=3 E=4 G=5 H=6 J=7 I=8 L=9 M=10 N=11 O=12 P=13 R=14 S=15 T=16 U=17 Y=18 SPACE=19 DASH=20. Codes 21..31 are never driven.
- ROM contents (length L, maximum 8):
  - sel 0 = ULUS (L=4)
  - sel 1 = SIHHIYE (L=7)
  - sel 2 = MALTEPE (L=7)
  - sel 3 = TANDOGAN (L=8)
- Reset:
  - Outputs: all four digits = 20 (DASH), busy=0, done=0.
  - Internal: state=IDLE, frame=0, tick counter=0.
- Virtual stream S: the message followed by four SPACEs; any index <0 or >=L reads as SPACE.
- Frame f displays thousands=S[f-3], hundreds=S[f-2], tens=S[f-1], ones=S[f].
- Frames run f=0..L+3 (L+4 frames); the last frame is all SPACE.
- FSM states:
  - IDLE: digits held at DASH, busy=0. On start: latch station_sel, set f=0, clear the counter, go to SCROLL. The digits show frame 0 and busy=1 from the same clock edge that samples start.
  - SCROLL: the counter increments each cycle. When counter==TICK_CYCLES-1: clear the counter and advance f, so each frame is held exactly TICK_CYCLES cycles.
    - On the tick at f=L+3 (one-shot mode): go to DONE.
  - DONE: one cycle. done=1, digits = DASH, busy=0; then IDLE.
- Boundary conditions:
  - start during SCROLL: restart at frame 0 with the newly latched station_sel, counter cleared.
  - stop during SCROLL: on the next edge, return to IDLE with digits = DASH; done is NOT pulsed.
  - start and stop in the same cycle: start wins.
  - stop in IDLE or DONE: ignored.
  - start in DONE: treated as in IDLE (DONE→SCROLL; done still pulses that cycle).
  - rst_n low at any point, including mid-scroll: immediately forces the reset values; no partial frame persists.
  - station_sel changes while busy: no effect.

Optional Feature:
- Macro: SCROLL_LOOP_EN.
- Defined: on the tick at f=L+3, wrap to f=0 and keep scrolling indefinitely; DONE is never entered and done stays 0. Only stop, a new start, or reset leaves SCROLL.
- Not defined: one-shot behaviour as specified above.

Test Plan (TICK_CYCLES=4):
- Reset: hold rst_n=0 → digits 20/20/20/20, busy=0, done=0. Release → values unchanged while idle.
- start with sel=0 (ULUS) → frame 0 = 19/19/19/17 for 4 cycles, then:
  - frame 1 = 19/19/17/9
  - frame 3 = 17/9/17/15
  - frames 4..7 shift the text out
  - after frame 7 (19/19/19/19): one done pulse, then digits = 20 and busy=0. Total busy = 32 cycles.
- start with sel=3 (TANDOGAN) → frame 7 = 12/5/0/11; 12 frames total, then done.
- start sel=1, stop at frame 2 → next edge: digits 20, busy=0, done never asserted.
- start sel=2 during frame 5 of sel=1, with stop asserted in the same cycle → restart at MALTEPE frame 0 (19/19/19/10), counter cleared.
- With SCROLL_LOOP_EN defined, sel=0 → after frame 7 the next frame is 19/19/19/17 again; done stays 0 across 3 loops; stop → IDLE.
